// File: rtl/dispatch_pkg.sv
// Shared types for the block dispatcher: controller states and core slot encodings.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dispatch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } dispatch_state_t;

  // Slot encodings as {core_reset, core_start}; the slot state lives in the outputs.
  localparam logic [1:0] SLOT_FREE = 2'b10;
  localparam logic [1:0] SLOT_BUSY = 2'b01;

endpackage

// File: rtl/priority_pick.sv
// Lowest-index request picker: valid flag plus binary index of the first set bit.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides whether to act on the pick.
module priority_pick #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  output logic          vld,
  output logic [IW-1:0] idx
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    vld = 1'b0;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        vld = 1'b1;
        idx = IW'(i);
      end
    end
  end

endmodule

// File: rtl/block_dispatcher.sv
// Splits a kernel launch into fixed-size blocks and hands them to free cores, one per cycle.
// Latency: first core_start 2 edges after start is sampled; done 1 edge after the last retire.
// Backpressure: blocks wait while no core is free; core_done is the only return path.
module block_dispatcher
  import dispatch_pkg::*;
#(
  parameter int NUM_CORES          = 2,
  parameter int THREADS_PER_BLOCK  = 4,
  parameter int THREAD_COUNT_WIDTH = 8
) (
  input  logic                                                    clk,
  input  logic                                                    reset,
  input  logic                                                    start,
  input  logic [THREAD_COUNT_WIDTH-1:0]                           thread_count,
  output logic [NUM_CORES-1:0]                                    core_start,
  output logic [NUM_CORES-1:0]                                    core_reset,
  output logic [NUM_CORES-1:0][THREAD_COUNT_WIDTH-1:0]            core_block_id,
  output logic [NUM_CORES-1:0][$clog2(THREADS_PER_BLOCK):0]       core_thread_count,
  input  logic [NUM_CORES-1:0]                                    core_done,
  output logic                                                    done
);

  localparam int TW  = THREAD_COUNT_WIDTH;
  localparam int BW  = TW + 1;                       // block counters need one spare bit
  localparam int LOG = $clog2(THREADS_PER_BLOCK);
  localparam int CW  = LOG + 1;
  localparam int EW  = BW + LOG;                     // room for dispatched*TPB
  localparam int IW  = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int RW  = $clog2(NUM_CORES + 1);

  dispatch_state_t state_q, state_d;

  logic [TW-1:0]        latched_tc;
  logic [BW-1:0]        total_blocks;
  logic [BW-1:0]        dispatched;
  logic [BW-1:0]        retired;
  logic [BW-1:0]        launch_blocks;
  logic [NUM_CORES-1:0] free_vec;
  logic [NUM_CORES-1:0] retire_vec;
  logic                 pick_vld;
  logic [IW-1:0]        pick_idx;
  logic                 dispatch_fire;
  logic [RW-1:0]        retire_cnt;
  logic [EW-1:0]        remaining;
  logic [CW-1:0]        dispatch_count;
  logic                 launch;
  logic                 done_set;
  logic                 done_clr;

  // Classify each core slot from its output pair and find retiring cores.
  always_comb begin
    free_vec   = '0;
    retire_vec = '0;
    retire_cnt = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      free_vec[i] = ({core_reset[i], core_start[i]} == SLOT_FREE);
      if (state_q == RUN && {core_reset[i], core_start[i]} == SLOT_BUSY && core_done[i]) begin
        retire_vec[i] = 1'b1;
        retire_cnt    = retire_cnt + RW'(1);
      end
    end
  end

  priority_pick #(
    .N  (NUM_CORES),
    .IW (IW)
  ) u_pick (
    .req (free_vec),
    .vld (pick_vld),
    .idx (pick_idx)
  );

  // Block sizing: ceiling division at launch, and the tail block gets the remainder.
  always_comb begin
    launch_blocks  = (BW'(thread_count) + BW'(THREADS_PER_BLOCK - 1)) >> LOG;
    remaining      = EW'(latched_tc) - (EW'(dispatched) << LOG);
    dispatch_count = (remaining >= EW'(THREADS_PER_BLOCK)) ? CW'(THREADS_PER_BLOCK) : CW'(remaining);
    dispatch_fire  = (state_q == RUN) && (dispatched < total_blocks) && pick_vld;
  end

  // Controller next state plus the launch / done strobes it implies.
  always_comb begin
    state_d  = state_q;
    launch   = 1'b0;
    done_set = 1'b0;
    done_clr = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        state_d = RUN;
        launch  = 1'b1;
      end
      RUN: if (retired == total_blocks) begin
        state_d  = DONE;
        done_set = 1'b1;
      end
      DONE: if (!start) begin
        state_d  = IDLE;
        done_clr = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Controller state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Launch latch, block counters and the done flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      latched_tc   <= '0;
      total_blocks <= '0;
      dispatched   <= '0;
      retired      <= '0;
      done         <= 1'b0;
    end else begin
      if (launch) begin
        latched_tc   <= thread_count;
        total_blocks <= launch_blocks;
        dispatched   <= '0;
        retired      <= '0;
      end else begin
        if (dispatch_fire)           dispatched <= dispatched + BW'(1);
        if (retire_cnt != '0)        retired    <= retired + BW'(retire_cnt);
      end
      if (done_set)      done <= 1'b1;
      else if (done_clr) done <= 1'b0;
    end
  end

  // Per-core start/reset pair and assignment; a core cannot retire and be picked in one cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      core_start        <= '0;
      core_reset        <= '1;
      core_block_id     <= '0;
      core_thread_count <= '0;
    end else begin
      for (int i = 0; i < NUM_CORES; i++) begin
        if (retire_vec[i]) begin
          core_start[i] <= 1'b0;
          core_reset[i] <= 1'b1;
        end else if (dispatch_fire && pick_idx == IW'(i)) begin
          core_start[i]        <= 1'b1;
          core_reset[i]        <= 1'b0;
          core_block_id[i]     <= dispatched[TW-1:0];
          core_thread_count[i] <= dispatch_count;
        end
      end
    end
  end

endmodule

// File: tb/tb_block_dispatcher.sv
// Directed bench for block_dispatcher with NUM_CORES=2, TPB=4, width 8.
// Inputs change just after the falling edge; outputs are checked at the falling edge.
// Each scenario leaves the dispatcher idle with all cores free.
module tb_block_dispatcher;

  logic            clk;
  logic            reset;
  logic            start;
  logic [7:0]      thread_count;
  logic [1:0]      core_start;
  logic [1:0]      core_reset;
  logic [1:0][7:0] core_block_id;
  logic [1:0][2:0] core_thread_count;
  logic [1:0]      core_done;
  logic            done;

  int errors = 0;
  int checks = 0;

  block_dispatcher #(
    .NUM_CORES          (2),
    .THREADS_PER_BLOCK  (4),
    .THREAD_COUNT_WIDTH (8)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .thread_count      (thread_count),
    .core_start        (core_start),
    .core_reset        (core_reset),
    .core_block_id     (core_block_id),
    .core_thread_count (core_thread_count),
    .core_done         (core_done),
    .done              (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, required to end earlier", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; thread_count = 8'd0; core_done = 2'b00;
    repeat (2) step();
    checks++; if (core_reset !== 2'b11) begin errors++; $display("FAIL rst_core_reset: got %b expected 11", core_reset); end
    checks++; if (core_start !== 2'b00) begin errors++; $display("FAIL rst_core_start: got %b expected 00", core_start); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b expected 0", done); end
    checks++; if (core_block_id !== 16'h0000) begin errors++; $display("FAIL rst_block_id: got %h expected 0000", core_block_id); end
    checks++; if (core_thread_count !== 6'd0) begin errors++; $display("FAIL rst_thread_count: got %h expected 0", core_thread_count); end
    reset = 1'b1;
    step();
  endtask

  task automatic test_two_blocks();
    start = 1'b1; thread_count = 8'd8;
    step();
    checks++; if (core_start !== 2'b00) begin errors++; $display("FAIL t1_run_no_start: got %b expected 00", core_start); end
    step();
    checks++; if (core_start !== 2'b01) begin errors++; $display("FAIL t1_core0_start: got %b expected 01", core_start); end
    checks++; if (core_block_id[0] !== 8'd0 || core_thread_count[0] !== 3'd4) begin errors++; $display("FAIL t1_core0_asg: got id %0d cnt %0d expected 0 4", core_block_id[0], core_thread_count[0]); end
    step();
    checks++; if (core_start !== 2'b11 || core_reset !== 2'b00) begin errors++; $display("FAIL t1_core1_start: got start %b reset %b expected 11 00", core_start, core_reset); end
    checks++; if (core_block_id[1] !== 8'd1 || core_thread_count[1] !== 3'd4) begin errors++; $display("FAIL t1_core1_asg: got id %0d cnt %0d expected 1 4", core_block_id[1], core_thread_count[1]); end
    core_done = 2'b01;
    step();
    checks++; if (core_start !== 2'b10 || core_reset !== 2'b01 || done !== 1'b0) begin errors++; $display("FAIL t1_retire0: got start %b reset %b done %b expected 10 01 0", core_start, core_reset, done); end
    core_done = 2'b10;
    step();
    checks++; if (core_start !== 2'b00 || done !== 1'b0) begin errors++; $display("FAIL t1_retire1: got start %b done %b expected 00 0", core_start, done); end
    core_done = 2'b00;
    step();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL t1_done: got %b expected 1", done); end
    start = 1'b0;
    step();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL t1_done_clear: got %b expected 0", done); end
  endtask

  task automatic test_tail_block();
    start = 1'b1; thread_count = 8'd10;
    repeat (3) step();
    checks++; if (core_thread_count[0] !== 3'd4 || core_thread_count[1] !== 3'd4 || core_block_id[1] !== 8'd1) begin errors++; $display("FAIL t2_first_pair: got cnt %0d %0d id1 %0d expected 4 4 1", core_thread_count[0], core_thread_count[1], core_block_id[1]); end
    core_done = 2'b01;
    step();
    core_done = 2'b00;
    checks++; if (core_reset[0] !== 1'b1 || core_start[0] !== 1'b0) begin errors++; $display("FAIL t2_core0_reset_gap: got reset %b start %b expected 1 0", core_reset[0], core_start[0]); end
    step();
    checks++; if (core_start[0] !== 1'b1 || core_reset[0] !== 1'b0) begin errors++; $display("FAIL t2_core0_restart: got start %b reset %b expected 1 0", core_start[0], core_reset[0]); end
    checks++; if (core_block_id[0] !== 8'd2 || core_thread_count[0] !== 3'd2) begin errors++; $display("FAIL t2_tail_asg: got id %0d cnt %0d expected 2 2", core_block_id[0], core_thread_count[0]); end
    core_done = 2'b11;
    step();
    core_done = 2'b00;
    checks++; if (done !== 1'b0 || core_start !== 2'b00) begin errors++; $display("FAIL t2_retire_all: got done %b start %b expected 0 00", done, core_start); end
    step();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL t2_done: got %b expected 1", done); end
    start = 1'b0;
    step();
  endtask

  task automatic test_zero_threads();
    start = 1'b1; thread_count = 8'd0;
    step();
    checks++; if (done !== 1'b0 || core_start !== 2'b00) begin errors++; $display("FAIL t3_edge1: got done %b start %b expected 0 00", done, core_start); end
    step();
    checks++; if (done !== 1'b1 || core_start !== 2'b00) begin errors++; $display("FAIL t3_edge2: got done %b start %b expected 1 00", done, core_start); end
    start = 1'b0;
    step();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL t3_done_clear: got %b expected 0", done); end
  endtask

  task automatic test_back_to_back_retire();
    start = 1'b1; thread_count = 8'd8;
    repeat (3) step();
    core_done = 2'b11;
    step();
    core_done = 2'b00;
    checks++; if (core_start !== 2'b00 || core_reset !== 2'b11 || done !== 1'b0) begin errors++; $display("FAIL t4_dual_retire: got start %b reset %b done %b expected 00 11 0", core_start, core_reset, done); end
    step();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL t4_done: got %b expected 1", done); end
    start = 1'b0;
    step();
  endtask

  task automatic test_async_reset();
    start = 1'b1; thread_count = 8'd8;
    repeat (3) step();
    checks++; if (core_start !== 2'b11 || core_block_id[1] !== 8'd1) begin errors++; $display("FAIL t5_pre_abort: got start %b id1 %0d expected 11 1", core_start, core_block_id[1]); end
    #2 reset = 1'b0;
    #1;
    checks++; if (core_reset !== 2'b11 || core_start !== 2'b00 || done !== 1'b0) begin errors++; $display("FAIL t5_async: got reset %b start %b done %b expected 11 00 0", core_reset, core_start, done); end
    checks++; if (core_block_id[1] !== 8'd0) begin errors++; $display("FAIL t5_async_id: got %0d expected 0", core_block_id[1]); end
    start = 1'b0;
    step();
    reset = 1'b1;
    step();
    start = 1'b1;
    repeat (2) step();
    checks++; if (core_start !== 2'b01 || core_block_id[0] !== 8'd0) begin errors++; $display("FAIL t5_restart: got start %b id0 %0d expected 01 0", core_start, core_block_id[0]); end
    reset = 1'b0; start = 1'b0;
    step();
    reset = 1'b1;
    step();
  endtask

  task automatic test_done_hold();
    start = 1'b1; thread_count = 8'd4;
    repeat (2) step();
    core_done = 2'b01;
    step();
    core_done = 2'b00;
    step();
    for (int k = 0; k < 5; k++) begin
      checks++; if (done !== 1'b1 || core_start !== 2'b00) begin errors++; $display("FAIL t6_hold_%0d: got done %b start %b expected 1 00", k, done, core_start); end
      step();
    end
    start = 1'b0;
    step();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL t6_release: got %b expected 0", done); end
    start = 1'b1; thread_count = 8'd4;
    repeat (2) step();
    checks++; if (core_start !== 2'b01 || core_block_id[0] !== 8'd0 || core_thread_count[0] !== 3'd4) begin errors++; $display("FAIL t6_relaunch: got start %b id %0d cnt %0d expected 01 0 4", core_start, core_block_id[0], core_thread_count[0]); end
    step();
    checks++; if (core_start !== 2'b01) begin errors++; $display("FAIL t6_single_block: got %b expected 01", core_start); end
    core_done = 2'b01;
    step();
    core_done = 2'b00;
    step();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL t6_relaunch_done: got %b expected 1", done); end
    start = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_two_blocks();
    test_tail_block();
    test_zero_threads();
    test_back_to_back_retire();
    test_async_reset();
    test_done_hold();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/block_dispatcher.md
Name: block_dispatcher

Overview:
Kernel-level controller that splits a launch of `thread_count` threads into blocks of THREADS_PER_BLOCK and hands them to NUM_CORES compute cores. It drives each core's start/reset pair and the block id / thread count each core runs. It collects per-core done, recycles free cores, and raises `done` when every block has retired. It sits between the device control register and the per-core schedulers.

Parameters:
NUM_CORES, 2, number of compute cores served
THREADS_PER_BLOCK, 4, threads per block, power of two ≥1
THREAD_COUNT_WIDTH, 8, width of thread_count, block ids and block counters

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset)
start  input  1  kernel launch level; sampled in IDLE
thread_count  input  THREAD_COUNT_WIDTH  total threads for the kernel, latched at launch
core_start  output  NUM_CORES  per-core start level
core_reset  output  NUM_CORES  per-core synchronous reset to core, active-high
core_block_id  output  NUM_CORES x THREAD_COUNT_WIDTH  block index assigned to core i
core_thread_count  output  NUM_CORES x ($clog2(THREADS_PER_BLOCK)+1)  active threads in core i's block
core_done  input  NUM_CORES  per-core block-complete flag
done  output  1  kernel complete

Behaviour:
- Reset (reset=0, async): state=IDLE, done=0, core_start=0, core_reset=all 1s, core_block_id=0, core_thread_count=0, counters=0.
- States:
  - IDLE: when start=1, latch thread_count; total_blocks=ceil(thread_count/THREADS_PER_BLOCK), computed as (tc+TPB-1)>>log2(TPB) at THREAD_COUNT_WIDTH+1 bits. Clear dispatched and retired counters; go to RUN.
  - RUN: if retired==total_blocks, set done<=1 and go to DONE. This also covers thread_count=0 on the first RUN cycle.
  - DONE: done held 1 while start=1. When start=0, set done<=0 and go to IDLE.
- Core slot states, derived from outputs:
  - FREE: core_reset=1, core_start=0.
  - BUSY: core_reset=0, core_start=1.
- Dispatch (RUN only, at most one per cycle):
  - Applies when dispatched<total_blocks and at least one core is FREE.
  - Target is the lowest-index FREE core i. Next edge sets core_reset[i]=0, core_start[i]=1, core_block_id[i]=dispatched.
  - core_thread_count[i]=min(TPB, latched_tc − dispatched*TPB).
  - dispatched increments by 1.
- Retire (RUN only, every core in parallel):
  - Applies to any BUSY core with core_done[i]=1.
  - Next edge sets core_start[i]=0, core_reset[i]=1; retired increments by the number retiring this cycle (popcount).
  - A core retiring this cycle is not FREE for dispatch until the following cycle, so core_reset is high for ≥1 cycle.
- core_done is ignored for FREE cores and outside RUN.
- Counters never wrap: dispatched ≤ total_blocks, retired ≤ dispatched.
- Reset asserted mid-run aborts immediately to reset values. No retire accounting is kept.
- Latency:
  - The first core's start rises 2 edges after start is sampled (IDLE→RUN, then dispatch).
  - done rises 1 edge after the edge that retires the last block.

Decomposition:
- Shared package `dispatch_pkg`:
  - enum dispatch_state_t {IDLE, RUN, DONE}.
  - localparam for core slot encodings FREE/BUSY.
- One sub-module `priority_pick`: parameterised lowest-index one-hot/index encoder over the FREE vector, outputting valid+index.
- All counters and state stay in block_dispatcher.

Test Plan:
1. NUM_CORES=2, TPB=4, thread_count=8, start=1:
   - core0 gets block 0, count 4, one cycle later core1 gets block 1, count 4.
   - Pulse core_done on both → done=1 one cycle after the retire edge.
2. thread_count=10:
   - total_blocks=3; blocks 0,1 get count 4.
   - After core0 done, core0 is reset ≥1 cycle, then restarts with block_id=2, core_thread_count=2.
3. thread_count=0, start=1:
   - No core_start ever asserted; done=1 two edges after start sampled.
4. thread_count=8, core_done asserted on cores 0 and 1 in the same cycle:
   - retired +=2 in one edge; done=1 the next edge.
5. Mid-run (block 1 dispatched), drive reset=0 asynchronously:
   - All core_reset=1, core_start=0, done=0 without waiting for a clock edge.
   - After release plus start, dispatch restarts from block 0.
6. After done=1, hold start=1 for 5 cycles:
   - done stays 1, no dispatch.
   - start=0 → done=0, state IDLE; a new start with thread_count=4 dispatches block 0 only.
